// File: rtl/ct_wrr_arb.sv
// Packet-aware weighted round-robin arbiter: merges RADIX ready/valid streams onto one output,
// granting whole packets and allowing up to weight[n] packets per turn.
module ct_wrr_arb #(
    parameter int unsigned RADIX = 2,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned EOP   = 0,
    parameter int unsigned WBITS = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [RADIX*WIDTH-1:0] i_data,
    input  logic [RADIX-1:0]       i_valid,
    output logic [RADIX-1:0]       o_ready,
    input  logic [RADIX*WBITS-1:0] i_weights,
    output logic                   o_valid,
    output logic [WIDTH-1:0]       o_data,
    input  logic                   i_ready,
    output logic [RADIX-1:0]       o_grant
);

    localparam int unsigned RADBITS = $clog2(RADIX);

    typedef enum logic [0:0] {StArb, StPkt} state_e;

    state_e             state_q, state_d;
    logic [RADBITS-1:0] cur_q, cur_d;
    logic [WBITS-1:0]   credit_q, credit_d;

    logic               found;
    logic [RADBITS-1:0] cand;
    logic [RADBITS-1:0] win;
    logic [WBITS-1:0]   weight;
    logic               beat;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StArb;
            cur_q    <= '0;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            credit_q <= credit_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        credit_d = credit_q;
        o_valid  = 1'b0;
        o_data   = '0;
        o_ready  = '0;
        o_grant  = '0;
        found    = 1'b0;
        cand     = '0;
        win      = '0;
        weight   = '0;
        beat     = 1'b0;

        unique case (state_q)
            StArb: begin
                if (credit_q != '0 && i_valid[cur_q]) begin
                    state_d = StPkt;
                end else begin
                    // Scan starts just after the last grantee and ends on it.
                    for (int k = 1; k <= int'(RADIX); k++) begin
                        cand = RADBITS'((int'(cur_q) + k) % int'(RADIX));
                        if (!found && i_valid[cand]) begin
                            found = 1'b1;
                            win   = cand;
                        end
                    end
                    if (found) begin
                        weight   = i_weights[int'(win)*int'(WBITS) +: WBITS];
                        cur_d    = win;
                        credit_d = (weight == '0) ? WBITS'(1) : weight;
                        state_d  = StPkt;
                    end
                end
            end
            StPkt: begin
                o_valid        = i_valid[cur_q];
                o_data         = i_data[int'(cur_q)*int'(WIDTH) +: WIDTH];
                o_ready[cur_q] = i_ready;
                o_grant[cur_q] = 1'b1;
                beat           = o_valid && i_ready;
                if (beat && o_data[EOP]) begin
                    credit_d = (credit_q != '0) ? credit_q - WBITS'(1) : credit_q;
                    state_d  = StArb;
                end
            end
            default: state_d = StArb;
        endcase
    end

endmodule

// File: tb/tb_ct_wrr_arb.sv
// Directed bench for ct_wrr_arb (RADIX=3): reset, grant order, weights, packet lock,
// credit forfeit and reset mid-packet.
module tb_ct_wrr_arb;

    localparam int unsigned RADIX = 3;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned WBITS = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [RADIX*WIDTH-1:0] i_data;
    logic [RADIX-1:0]       i_valid;
    logic [RADIX-1:0]       o_ready;
    logic [RADIX*WBITS-1:0] i_weights;
    logic                   o_valid;
    logic [WIDTH-1:0]       o_data;
    logic                   i_ready;
    logic [RADIX-1:0]       o_grant;

    int n_cmp = 0;
    int n_err = 0;

    ct_wrr_arb #(
        .RADIX(RADIX),
        .WIDTH(WIDTH),
        .EOP  (0),
        .WBITS(WBITS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_weights(i_weights),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .i_ready  (i_ready),
        .o_grant  (o_grant)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-beat packets: input n carries 8'h{n}1 (EOP bit 0 set).
    task automatic set_single();
        i_data = {8'h21, 8'h11, 8'h01};
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            check_eq("rst_valid", 32'(o_valid), 32'd0);
            check_eq("rst_ready", 32'(o_ready), 32'd0);
            check_eq("rst_grant", 32'(o_grant), 32'd0);
        end
        reset = 1'b1;
    endtask

    // Expects alternating grant/arbitration cycles with the grantees listed as digits.
    task automatic expect_order(input string s);
        for (int i = 0; i < s.len(); i++) begin
            int n;
            n = int'(s[i]) - 48;
            tick();
            check_eq("ord_grant", 32'(o_grant), 32'(1 << n));
            check_eq("ord_valid", 32'(o_valid), 32'd1);
            check_eq("ord_ready", 32'(o_ready), 32'(1 << n));
            check_eq("ord_data", 32'(o_data), 32'h01 + 32'h10 * 32'(n));
            tick();
            check_eq("arb_valid", 32'(o_valid), 32'd0);
            check_eq("arb_grant", 32'(o_grant), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        i_ready   = 1'b1;
        i_valid   = 3'b111;
        i_weights = {2'd1, 2'd1, 2'd1};
        set_single();

        // Reset held with all valid, then equal weights starting from input 1.
        do_reset(3);
        expect_order("120120");

        // Weighted: w0=2, w1=1, w2=0 (treated as 1).
        i_weights = {2'd0, 2'd1, 2'd2};
        do_reset(1);
        expect_order("12001200");

        // Packet lock: 4-beat packet on input 1, backpressure after beat 2, input 0 waiting.
        i_weights = {2'd1, 2'd1, 2'd1};
        i_valid   = 3'b011;
        i_data    = {8'h21, 8'hA0, 8'h01};
        do_reset(1);
        tick();
        #1;
        check_eq("lock_b1_grant", 32'(o_grant), 32'b010);
        check_eq("lock_b1_ready", 32'(o_ready), 32'b010);
        check_eq("lock_b1_data", 32'(o_data), 32'hA0);
        tick();
        i_data[15:8] = 8'hA2;
        #1;
        check_eq("lock_b2_grant", 32'(o_grant), 32'b010);
        check_eq("lock_b2_data", 32'(o_data), 32'hA2);
        tick();
        i_data[15:8] = 8'hA4;
        i_ready      = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check_eq("lock_stall_ready", 32'(o_ready), 32'b000);
            check_eq("lock_stall_grant", 32'(o_grant), 32'b010);
            check_eq("lock_stall_valid", 32'(o_valid), 32'd1);
            tick();
        end
        i_ready = 1'b1;
        #1;
        check_eq("lock_b3_ready", 32'(o_ready), 32'b010);
        check_eq("lock_b3_data", 32'(o_data), 32'hA4);
        tick();
        i_data[15:8] = 8'hA7;
        #1;
        check_eq("lock_b4_grant", 32'(o_grant), 32'b010);
        check_eq("lock_b4_data", 32'(o_data), 32'hA7);
        tick();
        i_valid = 3'b001;
        #1;
        check_eq("lock_arb_grant", 32'(o_grant), 32'b000);
        check_eq("lock_arb_valid", 32'(o_valid), 32'd0);
        tick();
        check_eq("lock_next_grant", 32'(o_grant), 32'b001);
        check_eq("lock_next_ready", 32'(o_ready), 32'b001);
        check_eq("lock_next_data", 32'(o_data), 32'h01);

        // Credit forfeit: input 0 (w0=3) sends one packet, drops valid, input 2 takes over.
        i_weights = {2'd1, 2'd1, 2'd3};
        i_valid   = 3'b001;
        set_single();
        do_reset(1);
        expect_order("0");
        i_valid = 3'b100;
        tick();
        check_eq("forfeit_grant2", 32'(o_grant), 32'b100);
        i_valid = 3'b101;
        tick();
        check_eq("forfeit_arb", 32'(o_grant), 32'b000);
        expect_order("0002");

        // Reset during beat 2 of a 3-beat packet from input 2.
        i_weights = {2'd1, 2'd1, 2'd1};
        i_valid   = 3'b100;
        i_data    = {8'h20, 8'h11, 8'h01};
        do_reset(1);
        tick();
        check_eq("mid_b1_grant", 32'(o_grant), 32'b100);
        check_eq("mid_b1_data", 32'(o_data), 32'h20);
        tick();
        i_data[23:16] = 8'h22;
        reset         = 1'b0;
        #1;
        check_eq("mid_b2_grant", 32'(o_grant), 32'b100);
        tick();
        check_eq("mid_rst_valid", 32'(o_valid), 32'd0);
        check_eq("mid_rst_grant", 32'(o_grant), 32'd0);
        check_eq("mid_rst_ready", 32'(o_ready), 32'd0);
        reset   = 1'b1;
        i_valid = 3'b111;
        set_single();
        expect_order("120");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ct_wrr_arb.md
# ct_wrr_arb

Packet-aware weighted round-robin arbiter that shares one streaming output channel among RADIX ready/valid producers. It sits where a plain merge would sit, in front of a shared link or sink that must see whole packets back-to-back. Each input may send up to a programmable number of packets per turn before the grant rotates. Arbitration is registered, so the block has no combinational path from any `i_valid` to the grant decision.

## Interface
- `RADIX`, default 2: number of inputs, ≥2.
- `WIDTH`, default 8: data width per input.
- `EOP`, default 0: bit index within each data word that marks end-of-packet.
- `WBITS`, default 2: width of each per-input weight and of the credit counter.
- `RADBITS`, derived as ceil(log2(RADIX)): grant index width.

Ports:
- `clk`  in  1: single clock. All state changes on the rising edge.
- `reset`  in  1: synchronous, active-low. A sampled 0 resets the block.
- `i_data`  in  RADIX*WIDTH: input words; input n occupies bits [n*WIDTH +: WIDTH].
- `i_valid`  in  RADIX: per-input valid.
- `o_ready`  out  RADIX: per-input ready.
- `i_weights`  in  RADIX*WBITS: packets allowed per turn, per input. A value of 0 is treated as 1.
- `o_valid`  out  1: output valid.
- `o_data`  out  WIDTH: output word.
- `i_ready`  in  1: downstream ready.
- `o_grant`  out  RADIX: one-hot marker of the input currently holding the grant. All zeros when no input holds it.

## Operation
- **Registered state**
  - `state`: S_ARB or S_PKT.
  - `cur`: RADBITS bits, the last or current grantee.
  - `credit`: WBITS bits, packets remaining in the current turn.
- **S_ARB** (no grant held)
  - Outputs: `o_valid`=0, `o_ready`=0, `o_grant`=0, `o_data`=don't care.
  - If `credit`≠0 and `i_valid[cur]`: keep `cur` and go to S_PKT. `credit` is unchanged.
  - Otherwise, scan cur+1, cur+2, … (mod RADIX), ending at `cur`, and take the first input with valid set. Load `cur` with that index, load `credit` with max(weight[winner],1), and go to S_PKT.
  - If a credited `cur` is not valid, its remaining credit is forfeited.
  - If no input is valid: stay in S_ARB with `cur` and `credit` unchanged.
- **S_PKT** (grant held by `cur`)
  - Outputs: `o_valid`=`i_valid[cur]`, `o_data`=`i_data[cur]`, `o_ready[cur]`=`i_ready`, all other `o_ready`=0, `o_grant`=onehot(cur).
  - A beat transfers when `o_valid` && `i_ready`.
  - On a beat whose data bit EOP is 1: decrement `credit` (saturating at 0) and go to S_ARB.
  - Any other beat, or a stall on either side: stay in S_PKT. The grant is never revoked mid-packet, whatever the other inputs do.
  - A single-beat packet is a beat with EOP=1.
- Weights are sampled only when `credit` is loaded. Changing `i_weights` mid-turn has no effect until the next load.
- **Reset**: `state`=S_ARB, `cur`=0, `credit`=0. The first arbitration therefore scans from input 1.
  - Reset mid-packet drops the grant immediately. The partial packet upstream is not recovered; the system reset covers the producers too.

## Timing
- Reset values: `o_valid`=0, `o_ready`=0, `o_grant`=0.
- Arbitration latency is 1 cycle.
  - Input valid in S_ARB at cycle N gives `o_valid` at cycle N+1, provided the input holds valid.
  - Producers must hold valid until ready (standard ready/valid).
- In S_PKT, data and ready are combinational passthroughs, with zero added latency.
- Every packet costs one S_ARB cycle, so peak throughput is L/(L+1) for packets of L beats.
- When several inputs are valid at once, the choice is fully determined by the scan order above.
- A starvation bound holds: an input that keeps valid asserted is granted within (RADIX−1)·2^WBITS packets.

## Test plan
- **Reset**
  - Stimulus: RADIX=3, hold `reset`=0 for 3 cycles with all `i_valid`=1.
  - Required: `o_valid`, `o_ready`, `o_grant` are 0 throughout. The first grant after release goes to input 1 (`o_grant`=3'b010) one cycle later.
- **Equal weights**
  - Stimulus: weights {1,1,1}, all inputs continuously offering 1-beat packets, `i_ready`=1.
  - Required: grant order 1,2,0,1,2,0. One beat every 2 cycles.
- **Weighted**
  - Stimulus: weights w0=2, w1=1, w2=0, all inputs valid with 1-beat packets.
  - Required: order 1,2,0,0,1,2,0,0. w2=0 behaves as 1.
- **Packet lock under backpressure**
  - Stimulus: input 1 sends a 4-beat packet (EOP on beat 4); `i_ready`=0 for 2 cycles after beat 2; input 0 valid the whole time.
  - Required: `o_ready[0]`=0 and `o_grant`=010 until beat 4 transfers. Input 0 is granted the cycle after the following S_ARB cycle.
- **Credit forfeit**
  - Stimulus: w0=3; input 0 sends one packet, then deasserts valid while input 2 is valid.
  - Required: input 2 is granted next. When input 0 is next granted, `credit` reloads to 3.
- **Reset mid-packet**
  - Stimulus: assert `reset`=0 during beat 2 of a 3-beat packet from input 2.
  - Required: next cycle `o_valid`=0 and `o_grant`=0. After release, `cur`=0 and the scan starts at input 1.
